// File: rtl/fixed_point_pkg.sv
// Shared fixed-point definitions for the perceptron datapath.
// Word format: {sign, Q_M integer bits, Q_N fractional bits}, sign-magnitude.
// Provides default format sizes, word/product width helpers and the divider
// state encoding. Both the multiplier and the divider import this package.
package fixed_point_pkg;

    localparam int unsigned SIGN_DEF = 1;
    localparam int unsigned Q_M_DEF  = 16;
    localparam int unsigned Q_N_DEF  = 16;

    // Total word width for a sign-magnitude fixed-point value.
    function automatic int unsigned fxp_word_width(input int unsigned sign,
                                                   input int unsigned q_m,
                                                   input int unsigned q_n);
        return sign + q_m + q_n;
    endfunction

    // Width of the exact magnitude product of two magnitudes (multiplier).
    function automatic int unsigned fxp_mag_product_width(input int unsigned q_m,
                                                          input int unsigned q_n);
        return 2 * (q_m + q_n);
    endfunction

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } div_state_t;

endpackage

// File: rtl/restoring_div_step.sv
// One restoring division iteration (combinational).
// Ports:
//   rem_i      current remainder (always < divisor)
//   num_msb_i  next numerator bit shifted into the remainder
//   divisor_i  divisor magnitude
//   rem_o      remainder after the conditional subtract
//   q_bit_o    quotient bit produced by this iteration
module restoring_div_step #(
    parameter int unsigned MAG_W = 32
) (
    input  logic [MAG_W-1:0] rem_i,
    input  logic             num_msb_i,
    input  logic [MAG_W-1:0] divisor_i,
    output logic [MAG_W-1:0] rem_o,
    output logic             q_bit_o
);

    // One extra bit: rem_i < divisor, so the shifted value is < 2*divisor.
    logic [MAG_W:0] shifted;
    logic [MAG_W:0] diff;

    assign shifted = {rem_i, num_msb_i};
    assign diff    = shifted - {1'b0, divisor_i};

    // diff < divisor whenever the subtract is taken, so its top bit is 0.
    always_comb begin
        q_bit_o = 1'b0;
        rem_o   = shifted[MAG_W-1:0];
        if (shifted >= {1'b0, divisor_i}) begin
            q_bit_o = 1'b1;
            rem_o   = diff[MAG_W-1:0];
        end
    end

endmodule

// File: rtl/fixed_point_divider.sv
// Sequential sign-magnitude fixed-point divider (restoring, 1 quotient bit/clk).
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   start_i            request a division (sampled only in IDLE)
//   dividend_in        numerator, sign-magnitude
//   divisor_in         denominator, sign-magnitude
//   busy_o             state is not IDLE
//   done_o             one-cycle pulse, results valid from this cycle
//   quotient_out       result, held until the next completed operation
//   div_by_zero_o      divisor magnitude was zero
//   overflow_o         quotient magnitude saturated
module fixed_point_divider
    import fixed_point_pkg::*;
#(
    parameter  int unsigned SIGN = SIGN_DEF,
    parameter  int unsigned Q_M  = Q_M_DEF,
    parameter  int unsigned Q_N  = Q_N_DEF,
    localparam int unsigned W    = fxp_word_width(SIGN, Q_M, Q_N)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [W-1:0] dividend_in,
    input  logic [W-1:0] divisor_in,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] quotient_out,
    output logic         div_by_zero_o,
    output logic         overflow_o
);

    localparam int unsigned MAG_W = Q_M + Q_N;
    localparam int unsigned NUM_W = Q_M + 2 * Q_N;
    localparam int unsigned CNT_W = $clog2(NUM_W + 1);

    div_state_t        state_q, state_d;
    // Numerator shifts out at the top while quotient bits shift in at the
    // bottom; after NUM_W iterations it holds the full quotient.
    logic [NUM_W-1:0]  num_q, num_d;
    logic [MAG_W-1:0]  div_q, div_d;
    logic [MAG_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sign_q, sign_d;
    logic              dz_q, dz_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [W-1:0]      quot_q, quot_d;
    logic              dz_out_q, dz_out_d;
    logic              ovf_q, ovf_d;

    logic [MAG_W-1:0]  a_mag;
    logic [MAG_W-1:0]  b_mag;
    logic              in_sign;
    logic [MAG_W-1:0]  step_rem;
    logic              step_qbit;
    logic              ovf_hit;
    logic [MAG_W-1:0]  res_mag;

    assign a_mag   = dividend_in[MAG_W-1:0];
    assign b_mag   = divisor_in[MAG_W-1:0];
    assign in_sign = dividend_in[W-1] ^ divisor_in[W-1];

    restoring_div_step #(
        .MAG_W (MAG_W)
    ) u_step (
        .rem_i     (rem_q),
        .num_msb_i (num_q[NUM_W-1]),
        .divisor_i (div_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_qbit)
    );

    // Result formatting: saturate on any set bit above the Q_M+Q_N field.
    assign ovf_hit = |num_q[NUM_W-1:MAG_W];
    assign res_mag = (dz_q || ovf_hit) ? {MAG_W{1'b1}} : num_q[MAG_W-1:0];

    // Next-state and output logic.
    always_comb begin
        state_d  = state_q;
        num_d    = num_q;
        div_d    = div_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        dz_d     = dz_q;
        done_d   = 1'b0;
        quot_d   = quot_q;
        dz_out_d = dz_out_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    sign_d = in_sign;
                    rem_d  = '0;
                    cnt_d  = '0;
                    if (b_mag == '0) begin
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        dz_d    = 1'b0;
                        num_d   = {a_mag, {Q_N{1'b0}}};
                        div_d   = b_mag;
                        state_d = DIVIDE;
                    end
                end
            end
            DIVIDE: begin
                num_d = {num_q[NUM_W-2:0], step_qbit};
                rem_d = step_rem;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(NUM_W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d   = 1'b1;
                // Zero magnitude never carries a negative sign.
                quot_d   = {sign_q & (|res_mag), res_mag};
                dz_out_d = dz_q;
                ovf_d    = ovf_hit & ~dz_q;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            num_q    <= '0;
            div_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            dz_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            quot_q   <= '0;
            dz_out_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            num_q    <= num_d;
            div_q    <= div_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            dz_q     <= dz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            quot_q   <= quot_d;
            dz_out_q <= dz_out_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign quotient_out  = quot_q;
    assign div_by_zero_o = dz_out_q;
    assign overflow_o    = ovf_q;

endmodule
